// File: rtl/jk_cmd_sequencer.sv
// rtl/jk_cmd_sequencer.sv - command FIFO and replay sequencer driving a JK flip-flop
//
// Purpose: accepts HOLD/RESET/SET/TOGGLE commands with a repeat count over a
// valid/ready handshake, buffers them in a DEPTH-entry FIFO and replays each
// as a registered j/k pair for cnt+1 clock cycles, back to back with no bubble.
//
// Optional feature macro: JK_SHADOW_CHECK_EN
//   defined   : shadow model of the driven flop's q (exp_q) plus a sticky
//               divergence flag (mismatch) once the flop state is known.
//   undefined : exp_q and mismatch tied 0, q_fb ignored.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   cmd_valid  command present
//   cmd_ready  FIFO can accept a command
//   cmd_op     00 HOLD, 01 RESET, 10 SET, 11 TOGGLE
//   cmd_cnt    repeat count; command driven for cmd_cnt+1 cycles
//   j, k       registered drive to the downstream flop
//   busy       command being issued or FIFO non-empty
//   fifo_count entries currently held
//   q_fb       q fed back from the driven flop
//   exp_q      shadow q
//   mismatch   sticky divergence flag

module jk_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [CNT_W-1:0]         cmd_cnt,
    output logic                     j,
    output logic                     k,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    input  logic                     q_fb,
    output logic                     exp_q,
    output logic                     mismatch
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 + CNT_W;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO: op and count stored together in one entry
    // ------------------------------------------------------------------
    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [1:0]       head_op;
    logic [CNT_W-1:0] head_cnt;

    assign cmd_ready  = (count != FULL_CNT);
    assign push       = cmd_valid && cmd_ready;
    assign fifo_empty = (count == '0);
    assign fifo_count = count;
    assign {head_op, head_cnt} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_op, cmd_cnt};
        end
    end

    // Pointers are AW bits wide, so DEPTH being a power of two makes the
    // natural overflow the modulo-DEPTH wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] remaining_nxt;
    logic             j_nxt;
    logic             k_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            j         <= 1'b0;
            k         <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            j         <= j_nxt;
            k         <= k_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        j_nxt         = j;
        k_nxt         = k;
        pop           = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop           = 1'b1;
                    j_nxt         = head_op[1];
                    k_nxt         = head_op[0];
                    remaining_nxt = head_cnt;
                    state_nxt     = ISSUE;
                end else begin
                    j_nxt = 1'b0;
                    k_nxt = 1'b0;
                end
            end
            ISSUE: begin
                if (remaining != '0) begin
                    remaining_nxt = remaining - CNT_W'(1);
                end else if (!fifo_empty) begin
                    // Chain straight into the next command so the flop sees
                    // no idle cycle between consecutive commands.
                    pop           = 1'b1;
                    j_nxt         = head_op[1];
                    k_nxt         = head_op[0];
                    remaining_nxt = head_cnt;
                end else begin
                    state_nxt = IDLE;
                    j_nxt     = 1'b0;
                    k_nxt     = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                j_nxt     = 1'b0;
                k_nxt     = 1'b0;
            end
        endcase
    end

    assign busy = (state == ISSUE) || !fifo_empty;

    // ------------------------------------------------------------------
    // Shadow model of the downstream flop
    // ------------------------------------------------------------------
`ifdef JK_SHADOW_CHECK_EN
    logic exp_q_r;
    logic synced;
    logic mismatch_r;

    // The flop samples the same registered j/k as this model on every edge,
    // so q_fb and exp_q should agree in every cycle once synced. Until a
    // RESET or SET pair has been sampled the flop's state is unknown and no
    // comparison is meaningful.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q_r    <= 1'b0;
            synced     <= 1'b0;
            mismatch_r <= 1'b0;
        end else begin
            if (synced && (q_fb != exp_q_r)) begin
                mismatch_r <= 1'b1;
            end
            if (j ^ k) begin
                synced <= 1'b1;
            end
            case ({j, k})
                2'b01:   exp_q_r <= 1'b0;
                2'b10:   exp_q_r <= 1'b1;
                2'b11:   exp_q_r <= ~exp_q_r;
                default: exp_q_r <= exp_q_r;
            endcase
        end
    end

    assign exp_q    = exp_q_r;
    assign mismatch = mismatch_r;
`else
    logic unused_q_fb;

    assign unused_q_fb = q_fb;
    assign exp_q       = 1'b0;
    assign mismatch    = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb/tb_jk_cmd_sequencer.sv - self-checking bench for jk_cmd_sequencer

module tb_jk_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
`ifdef JK_SHADOW_CHECK_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic             j;
    logic             k;
    logic             busy;
    logic [2:0]       fifo_count;
    logic             q_fb;
    logic             exp_q;
    logic             mismatch;

    jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_cnt    (cmd_cnt),
        .j          (j),
        .k          (k),
        .busy       (busy),
        .fifo_count (fifo_count),
        .q_fb       (q_fb),
        .exp_q      (exp_q),
        .mismatch   (mismatch)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit jk_next(input bit q, input bit [1:0] jk);
        case (jk)
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            2'b11:   return ~q;
            default: return q;
        endcase
    endfunction

    // Downstream JK flop driven by the DUT; q_fb can be forced low.
    bit fq = 1'b0;
    bit force_q = 1'b0;
    always @(posedge clk) fq <= jk_next(fq, {j, k});
    assign q_fb = force_q ? 1'b0 : fq;

    // ------------------------------------------------------------------
    // Reference model: accepted commands queue up, each popped command
    // expands into a stream of cnt+1 j/k pairs consumed one per edge.
    // ------------------------------------------------------------------
    bit [5:0] m_fifo[$];
    bit [1:0] m_stream[$];
    bit [1:0] m_jk = 2'b00;
    bit       m_iss = 1'b0;
    bit       m_acc = 1'b0;
    bit       m_expq = 1'b0;
    bit       m_sync = 1'b0;
    bit       m_mis = 1'b0;

    always @(posedge clk) begin
        bit       accept;
        bit [5:0] c;
        m_acc = 1'b0;
        if (rst) begin
            m_fifo.delete();
            m_stream.delete();
            m_jk   = 2'b00;
            m_iss  = 1'b0;
            m_expq = 1'b0;
            m_sync = 1'b0;
            m_mis  = 1'b0;
        end else begin
            if (m_sync && (q_fb != m_expq)) m_mis = 1'b1;
            if (m_jk == 2'b01 || m_jk == 2'b10) m_sync = 1'b1;
            m_expq = jk_next(m_expq, m_jk);
            accept = cmd_valid && (m_fifo.size() != DEPTH);
            if (m_stream.size() == 0 && m_fifo.size() != 0) begin
                c = m_fifo.pop_front();
                for (int i = 0; i <= int'(c[3:0]); i++) m_stream.push_back(c[5:4]);
            end
            if (m_stream.size() != 0) begin
                m_jk  = m_stream.pop_front();
                m_iss = 1'b1;
            end else begin
                m_jk  = 2'b00;
                m_iss = 1'b0;
            end
            if (accept) begin
                m_fifo.push_back({cmd_op, cmd_cnt});
                m_acc = 1'b1;
            end
        end
    end

    // Cycle-by-cycle scoreboard compare, away from the active edge.
    bit chk_en = 1'b0;
    int busy_cycles = 0;
    int max_fill = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("j", j, m_jk[1]);
            chk("k", k, m_jk[0]);
            chk("busy", busy, m_iss || (m_fifo.size() != 0));
            chk("fifo_count", fifo_count, m_fifo.size());
            chk("cmd_ready", cmd_ready, m_fifo.size() != DEPTH);
            chk("exp_q", exp_q, SHADOW ? m_expq : 1'b0);
            chk("mismatch", mismatch, SHADOW ? m_mis : 1'b0);
            if (busy) busy_cycles++;
            if (int'(fifo_count) > max_fill) max_fill = int'(fifo_count);
        end
    end

    task automatic push_cmd(input logic [1:0] op, input logic [3:0] cnt);
        bit ok;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cnt   = cnt;
        ok        = 1'b0;
        for (int b = 0; b < 200 && !ok; b++) begin
            @(posedge clk);
            #1;
            ok = m_acc;
        end
        if (!ok) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int b = 0; b < budget && !done; b++) begin
            @(negedge clk);
            done = !m_iss && (m_fifo.size() == 0);
        end
        if (!done) chk("idle_timeout", 0, 1);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [3:0] cnt;
        logic       ej;
        logic       ek;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int nb;
        int np;
        int active;
        bit seen0;
        bit forced;

        vecs[0] = '{op: 2'b10, cnt: 4'd0,  ej: 1'b1, ek: 1'b0};
        vecs[1] = '{op: 2'b01, cnt: 4'd0,  ej: 1'b0, ek: 1'b1};
        vecs[2] = '{op: 2'b11, cnt: 4'd3,  ej: 1'b1, ek: 1'b1};
        vecs[3] = '{op: 2'b00, cnt: 4'd2,  ej: 1'b0, ek: 1'b0};
        vecs[4] = '{op: 2'b10, cnt: 4'd15, ej: 1'b1, ek: 1'b0};
        vecs[5] = '{op: 2'b01, cnt: 4'd1,  ej: 1'b0, ek: 1'b1};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_cnt   = '0;

        // Reset held two cycles, then idle.
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_j", j, 0);
        chk("rst_k", k, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_count", fifo_count, 0);

        // Single commands from a table: busy lasts cnt+2 cycles, the pair
        // is present cnt+1 cycles (HOLD: all busy cycles are 00).
        foreach (vecs[i]) begin
            push_cmd(vecs[i].op, vecs[i].cnt);
            cmd_valid = 1'b0;
            nb = 0;
            np = 0;
            for (int b = 0; b < 40; b++) begin
                @(negedge clk);
                if (!busy) break;
                nb++;
                if ({j, k} == {vecs[i].ej, vecs[i].ek}) np++;
            end
            chk($sformatf("busy_len[%0d]", i), nb, int'(vecs[i].cnt) + 2);
            chk($sformatf("pair_len[%0d]", i), np,
                int'(vecs[i].cnt) + ((vecs[i].op == 2'b00) ? 2 : 1));
        end
        chk("flop_after_table", fq, 0);

        // TOGGLE cnt=3 then RESET cnt=1 back to back: no gap.
        busy_cycles = 0;
        push_cmd(2'b11, 4'd3);
        push_cmd(2'b01, 4'd1);
        cmd_valid = 1'b0;
        wait_idle(40);
        chk("b2b_busy_cycles", busy_cycles, 7);
        chk("b2b_flop_q", fq, 0);

        // DEPTH+2 HOLD cnt=15 with cmd_valid held high.
        busy_cycles = 0;
        max_fill = 0;
        for (int i = 0; i < DEPTH + 2; i++) push_cmd(2'b00, 4'd15);
        cmd_valid = 1'b0;
        wait_idle(200);
        chk("full_max_fill", max_fill, DEPTH);
        chk("full_busy_cycles", busy_cycles, 1 + (DEPTH + 2) * 16);

        // Reset during the 2nd cycle of TOGGLE cnt=7 with 2 queued.
        push_cmd(2'b11, 4'd7);
        push_cmd(2'b10, 4'd0);
        push_cmd(2'b01, 4'd0);
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_j", j, 0);
        chk("midrst_k", k, 0);
        chk("midrst_count", fifo_count, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        active = 0;
        for (int b = 0; b < 20; b++) begin
            @(negedge clk);
            if (j || k || busy) active++;
        end
        chk("midrst_no_issue", active, 0);

        // Shadow check: SET then TOGGLE cnt=2, q_fb forced low for one
        // cycle while the flop holds 1 mid-toggle.
        seen0  = 1'b0;
        forced = 1'b0;
        fork
            begin
                push_cmd(2'b10, 4'd0);
                push_cmd(2'b11, 4'd2);
                cmd_valid = 1'b0;
            end
            begin
                for (int b = 0; b < 30 && !forced; b++) begin
                    @(negedge clk);
                    if (j && k && !fq) seen0 = 1'b1;
                    if (j && k && fq && seen0) begin
                        force_q = 1'b1;
                        @(negedge clk);
                        force_q = 1'b0;
                        forced  = 1'b1;
                    end
                end
            end
        join
        wait_idle(30);
        chk("shadow_forced", forced, 1);
        chk("shadow_flop_q", fq, 0);
        chk("shadow_exp_q", exp_q, 0);
        chk("shadow_mismatch", mismatch, SHADOW);
        repeat (3) @(negedge clk);
        chk("shadow_mismatch_sticky", mismatch, SHADOW);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("shadow_mismatch_cleared", mismatch, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jk_cmd_sequencer.md
Name: jk_cmd_sequencer

Overview:
- Upstream driver for the team's JK flip-flop cells.
- Accepts HOLD/RESET/SET/TOGGLE commands with a repeat count over a valid/ready handshake and buffers them in a small FIFO.
- Replays each command as a registered j/k pair for the requested number of clock cycles, so JK stages can be sequenced without hand-written stimulus.
- Optionally keeps a shadow model of the driven flop's q and flags divergence.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, minimum 2.
- CNT_W, 4, width of the repeat-count field.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept a command.
- cmd_op  input  2  00 HOLD, 01 RESET, 10 SET, 11 TOGGLE.
- cmd_cnt  input  CNT_W  repeat count; command is driven for cmd_cnt+1 cycles.
- j  output  1  registered J drive to the downstream flop.
- k  output  1  registered K drive to the downstream flop.
- busy  output  1  command being issued, or FIFO non-empty.
- fifo_count  output  $clog2(DEPTH)+1  entries currently held.
- q_fb  input  1  q fed back from the driven flop; used only with the optional feature.
- exp_q  output  1  shadow q; 0 without the optional feature.
- mismatch  output  1  sticky divergence flag; 0 without the optional feature.

Behaviour:
- Reset values: j=0, k=0, busy=0, fifo_count=0, exp_q=0, mismatch=0. FIFO pointers cleared, FSM in IDLE, remaining counter 0.
- Reset mid-operation discards all queued and in-flight commands. On the next cycle j=k=0.
- Push:
  - cmd_ready = (fifo_count != DEPTH), combinational from the count.
  - A command is accepted on an edge where cmd_valid && cmd_ready.
  - cmd_op and cmd_cnt are stored together.
- FSM has two states, IDLE and ISSUE.
  - IDLE: if the FIFO is non-empty, pop on this edge. Load j,k from op bits (j=op[1], k=op[0]), set remaining=cnt, go to ISSUE. Otherwise j=k=0.
  - ISSUE, remaining>0: decrement remaining; j/k hold.
  - ISSUE, remaining==0, FIFO non-empty: pop the next command in the same edge. No bubble cycle.
  - ISSUE, remaining==0, FIFO empty: go to IDLE and set j=k=0.
- Latency: a command accepted at edge T into an empty FIFO while IDLE is popped at edge T+1. j/k are valid from after T+1 through edge T+2+cnt, where they change. The downstream flop samples the pair on cnt+1 edges (T+2 … T+2+cnt).
- No bypass: a push into an empty FIFO is not popped on the same edge.
- Simultaneous push and pop: both take effect and fifo_count is unchanged. When full, push is blocked; a pop on that edge frees a slot, and cmd_ready rises in the next cycle.
- Counts:
  - cmd_cnt = 2^CNT_W-1 drives for 2^CNT_W cycles.
  - The remaining counter never wraps.
  - fifo_count is always in 0..DEPTH.
  - Pointers wrap modulo DEPTH.
- busy = (state==ISSUE) || (fifo_count!=0).
- HOLD commands are issued like any other op: j=k=0 for cnt+1 cycles, still busy.

Optional Feature:
- Macro: JK_SHADOW_CHECK_EN.
- With the macro defined:
  - exp_q updates every edge from the current registered j/k using JK semantics: 00 hold, 01 ->0, 10 ->1, 11 invert.
  - A "synced" flag sets when a RESET or SET pair has been driven, i.e. after the edge at which the flop samples it. Before that, the downstream flop's power-up or post-reset state is unknown.
  - While synced, if q_fb != exp_q on any edge, mismatch sets and stays set until rst.
  - rst clears exp_q, synced and mismatch.
- Without the macro: exp_q and mismatch are tied 0, q_fb is unused, and no shadow logic is built.

Test Plan:
- rst held 2 cycles, then idle → j=k=0, busy=0, cmd_ready=1, fifo_count=0.
- Push SET cnt=0 at edge T → j=1,k=0 for exactly one cycle after T+1; driven flop q=1 after T+2; then j=k=0, busy=0.
- Push TOGGLE cnt=3, then RESET cnt=1 back-to-back → j=k=1 for 4 cycles, immediately followed by j=0,k=1 for 2 cycles with no gap. Flop q starting at 0 ends at 0.
- Hold cmd_valid high with DEPTH+2 HOLD cnt=15 commands, DEPTH=4 → cmd_ready drops when fifo_count=4. Exactly one push is accepted per pop; all 6 commands are issued, 16 cycles each.
- Assert rst during the 2nd cycle of TOGGLE cnt=7 with 2 queued → next cycle j=k=0, fifo_count=0, busy=0; queued commands are never issued.
- With JK_SHADOW_CHECK_EN: issue SET then TOGGLE cnt=2, with q_fb forced to 0 for one cycle mid-toggle → exp_q sequence 1,0,1,0 and mismatch=1 until rst. Without the macro, mismatch stays 0.
